wb_lsu: RTL and testbench
=========================

WB_LSU -- requirements
Module: wb_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, giving the width of ADR_O in byte-address bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum number of BUS cycles without ACK_I before an abort.
REQ-003 SHALL have port CLK_I, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_I, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_i, input, 1 bit: CPU memory request strobe, sampled only in IDLE.
REQ-006 SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port wdata_i, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port funct3_i, input, 3 bits: RV32 size code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-010 SHALL have port busy_o, output, 1 bit: transfer in progress.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1 bit: high with done_o when the transfer failed.
REQ-013 SHALL have port err_code_o, output, 2 bits: 01 = misaligned or illegal size, 10 = bus timeout, 00 = none.
REQ-014 SHALL have port rdata_o, output, 32 bits: extended load result.
REQ-015 SHALL have the Wishbone master outputs CYC_O, STB_O, WE_O (1 bit each), ADR_O (ADDR_WIDTH bits), DAT_O (32 bits) and SEL_O (4 bits).
REQ-016 SHALL have the Wishbone master inputs ACK_I (1 bit) and DAT_I (32 bits).

Function
REQ-017 SHALL use states IDLE, BUS, RDATA and DONE.
REQ-018 In IDLE with req_i=1, SHALL latch we_i, addr_i, wdata_i and funct3_i, then check the request:
- funct3 of 3, 6 or 7 is illegal;
- H/HU with addr[0]=1 is misaligned;
- W with addr[1:0]!=0 is misaligned.
An illegal or misaligned request SHALL go to DONE with err_code 01 and issue no bus cycle; any other request SHALL go to BUS.
REQ-019 In BUS, SHALL drive CYC_O=STB_O=1 and WE_O=latched we, and drive ADR_O=addr[ADDR_WIDTH-1:0]; upper address bits are silently dropped.
REQ-020 In BUS, SEL_O SHALL be:
- byte: 1<<addr[1:0];
- half: 0011 or 1100 selected by addr[1];
- word: 1111.
REQ-021 In BUS, DAT_O SHALL replicate store data: a byte across all 4 lanes, a half across both halves, a word unchanged.
REQ-022 In BUS, ACK_I=1 SHALL end the bus cycle: a store goes to DONE, a load goes to RDATA. The slave may assert ACK_I in the same cycle as STB_O.
REQ-023 In RDATA, SHALL drive CYC_O=STB_O=0 and capture DAT_I, because the slave delivers read data one cycle after ACK.
REQ-024 In RDATA, SHALL extract the lane given by addr[1:0], sign-extend it for B/H and zero-extend it for BU/HU, write the result to rdata_o, then go to DONE.
REQ-025 In BUS, a cycle counter SHALL count cycles with ACK_I=0. When the count reaches TIMEOUT, SHALL drop CYC_O/STB_O and go to DONE with err_code 10.
REQ-026 The timeout counter SHALL clear on entry to BUS and SHALL saturate rather than wrap.
REQ-027 In DONE, SHALL drive done_o=1 for exactly one cycle, with err_o=(err_code!=0), then return to IDLE.
REQ-028 busy_o SHALL be 1 in BUS and RDATA and 0 in IDLE and DONE.
REQ-029 CYC_O and STB_O SHALL be 0 outside BUS; DAT_O, ADR_O, SEL_O and WE_O are don't-care when STB_O=0.
REQ-030 req_i outside IDLE SHALL be ignored; a req_i asserted in DONE is not queued.
REQ-031 rdata_o SHALL hold its value until the next successful load completes; stores and errors SHALL leave it unchanged.
REQ-032 err_code_o SHALL be valid only while done_o=1 and SHALL be 00 otherwise.
REQ-033 Latency from the req_i cycle N with zero-wait ACK SHALL be: store done_o at N+2, load done_o at N+3, alignment error done_o at N+1.

Reset
REQ-034 RST_I=1 at a clock edge SHALL force state IDLE, clear the timeout counter and set every output to 0, including rdata_o.
REQ-035 Reset during BUS or RDATA SHALL drop CYC_O/STB_O at the next edge and SHALL produce no done_o pulse; reset overrides req_i in the same cycle.

Verification
REQ-036 Store word: SW 0x00000045 to 0x14 -> one BUS cycle with SEL_O=1111, ADR_O=0x14, DAT_O=0x00000045, done_o at N+2, err_o=0.
REQ-037 Load byte signed: memory word 0x80FF7F01 at 0x10, LB at 0x12 -> rdata_o=0xFFFFFFFF; LBU at 0x11 -> 0x0000007F; LH at 0x12 -> 0xFFFF80FF; done_o at N+3.
REQ-038 Store byte: SB 0xAB to 0x23 -> SEL_O=1000, DAT_O=0xABABABAB; a following LW at 0x20 shows only bits 31:24 changed.
REQ-039 Misaligned: LW at 0x06 -> no CYC_O ever, done_o=1 and err_code_o=01 at N+1; funct3=3 gives the same response.
REQ-040 Timeout: ACK_I held at 0 with TIMEOUT=4 -> STB_O high for 4 cycles, then done_o with err_code_o=10; rdata_o unchanged.
REQ-041 Reset mid-cycle: RST_I pulsed while in BUS -> CYC_O=0 the next cycle, no done_o, and a new request afterwards completes normally.

Source files
------------

// File: rtl/wb_lsu.sv
// Load/store unit bridging an RV32 core memory request to a single Wishbone classic cycle.
// Handles size/alignment checking, lane steering, load extension and a bus timeout.
module wb_lsu #(
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [2:0]            funct3_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [31:0]           rdata_o,
  output logic                  CYC_O,
  output logic                  STB_O,
  output logic                  WE_O,
  output logic [ADDR_WIDTH-1:0] ADR_O,
  output logic [31:0]           DAT_O,
  output logic [3:0]            SEL_O,
  input  logic                  ACK_I,
  input  logic [31:0]           DAT_I
);

  typedef enum logic [1:0] {IDLE, BUS, RDATA, DONE} state_t;

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t                state, state_next;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic [1:0]            err_q;
  logic [TW-1:0]         timer;
  logic [31:0]           rdata_q;
  logic                  req_bad;
  logic                  timed_out;
  logic [31:0]           lane_shift;
  logic [15:0]           half_lane;
  logic [31:0]           load_ext;

  // Only the low ADDR_WIDTH address bits reach the bus.
  if (ADDR_WIDTH < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH];
  end

  always_comb begin
    req_bad = 1'b0;
    case (funct3_i)
      3'd0, 3'd4: req_bad = 1'b0;
      3'd1, 3'd5: req_bad = addr_i[0];
      3'd2:       req_bad = |addr_i[1:0];
      default:    req_bad = 1'b1;
    endcase
  end

  assign timed_out = (state == BUS) && !ACK_I && ((int'(timer) + 1) >= TIMEOUT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_i) state_next = req_bad ? DONE : BUS;
      BUS: begin
        if (ACK_I)          state_next = we_q ? DONE : RDATA;
        else if (timed_out) state_next = DONE;
      end
      RDATA:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture, timeout counter and load result; the counter rests at zero outside BUS.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      err_q    <= '0;
      timer    <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && req_i) begin
        we_q     <= we_i;
        addr_q   <= addr_i[ADDR_WIDTH-1:0];
        wdata_q  <= wdata_i;
        funct3_q <= funct3_i;
        err_q    <= req_bad ? ERR_ALIGN : 2'b00;
      end
      if (state == BUS) begin
        if (!ACK_I && timer != TW'(TIMEOUT)) timer <= timer + 1'b1;
        if (timed_out) err_q <= ERR_TIMEOUT;
      end else begin
        timer <= '0;
      end
      if (state == RDATA) rdata_q <= load_ext;
    end
  end

  always_comb begin
    lane_shift = DAT_I >> {addr_q[1:0], 3'b000};
    half_lane  = addr_q[1] ? DAT_I[31:16] : DAT_I[15:0];
    case (funct3_q[1:0])
      2'd0:    load_ext = {{24{~funct3_q[2] & lane_shift[7]}}, lane_shift[7:0]};
      2'd1:    load_ext = {{16{~funct3_q[2] & half_lane[15]}}, half_lane};
      default: load_ext = DAT_I;
    endcase
  end

  // Bus outputs are forced to zero outside BUS so reset leaves every output low.
  always_comb begin
    CYC_O = (state == BUS);
    STB_O = (state == BUS);
    WE_O  = 1'b0;
    ADR_O = '0;
    SEL_O = 4'b0000;
    DAT_O = 32'h0;
    if (state == BUS) begin
      WE_O  = we_q;
      ADR_O = addr_q;
      case (funct3_q[1:0])
        2'd0: begin
          SEL_O = 4'b0001 << addr_q[1:0];
          DAT_O = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          SEL_O = addr_q[1] ? 4'b1100 : 4'b0011;
          DAT_O = {2{wdata_q[15:0]}};
        end
        default: begin
          SEL_O = 4'b1111;
          DAT_O = wdata_q;
        end
      endcase
    end
  end

  assign busy_o     = (state == BUS) || (state == RDATA);
  assign done_o     = (state == DONE);
  assign err_o      = done_o && (err_q != 2'b00);
  assign err_code_o = done_o ? err_q : 2'b00;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu against a small Wishbone memory slave with same-cycle ACK
// and read data returned one cycle after ACK.
module tb_wb_lsu;

  logic        CLK_I = 1'b0;
  logic        RST_I, req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [2:0]  funct3_i;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [31:0] rdata_o;
  logic        CYC_O, STB_O, WE_O;
  logic [23:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        ACK_I;
  logic [31:0] DAT_I;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];
  logic [31:0] rd_q;
  logic        ack_en;

  int          r_lat, r_stb;
  logic        r_saw, r_err, saw_done;
  logic [3:0]  r_sel;
  logic [23:0] r_adr;
  logic [31:0] r_dat, r_rdata;
  logic [1:0]  r_code;

  wb_lsu #(.ADDR_WIDTH(24), .TIMEOUT(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .funct3_i(funct3_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .rdata_o(rdata_o), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .ACK_I(ACK_I), .DAT_I(DAT_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Memory slave: zero-wait ACK, byte-lane writes, read data registered after ACK.
  assign ACK_I = CYC_O & STB_O & ack_en;
  assign DAT_I = rd_q;

  always @(posedge CLK_I) begin
    if (CYC_O && STB_O && ACK_I) begin
      if (WE_O) begin
        if (SEL_O[0]) mem[ADR_O[7:2]][7:0]   <= DAT_O[7:0];
        if (SEL_O[1]) mem[ADR_O[7:2]][15:8]  <= DAT_O[15:8];
        if (SEL_O[2]) mem[ADR_O[7:2]][23:16] <= DAT_O[23:16];
        if (SEL_O[3]) mem[ADR_O[7:2]][31:24] <= DAT_O[31:24];
      end else begin
        rd_q <= mem[ADR_O[7:2]];
      end
    end
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request in the current cycle and follows it to done_o (bounded),
  // then steps one more cycle so the unit is back in IDLE.
  task applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; funct3_i = f3;
    r_saw = 1'b0; r_stb = 0; r_sel = '0; r_adr = '0; r_dat = '0;
    @(posedge CLK_I); #1;
    req_i = 1'b0;
    r_lat = 1;
    while (!done_o && r_lat < 40) begin
      if (CYC_O) begin
        r_saw = 1'b1; r_sel = SEL_O; r_adr = ADR_O; r_dat = DAT_O;
      end
      if (STB_O) r_stb++;
      @(posedge CLK_I); #1;
      r_lat++;
    end
    r_err = err_o; r_code = err_code_o; r_rdata = rdata_o;
    @(posedge CLK_I); #1;
  endtask

  initial begin
    RST_I = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    funct3_i = '0; ack_en = 1'b1; rd_q = '0;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b0;

    checkOutput("reset_flags", {27'd0, busy_o, done_o, err_o, CYC_O, STB_O}, 32'h0);
    checkOutput("reset_rdata", rdata_o, 32'h0);
    checkOutput("reset_code", {30'd0, err_code_o}, 32'h0);

    applyStimulus(1'b1, 32'h14, 32'h45, 3'd2);
    checkOutput("sw_lat", r_lat, 2);
    checkOutput("sw_sel", {28'd0, r_sel}, 32'hF);
    checkOutput("sw_adr", {8'd0, r_adr}, 32'h14);
    checkOutput("sw_dat", r_dat, 32'h45);
    checkOutput("sw_err", {31'd0, r_err}, 32'h0);

    applyStimulus(1'b1, 32'h10, 32'h80FF7F01, 3'd2);
    applyStimulus(1'b1, 32'hFF000020, 32'h11223344, 3'd2);
    checkOutput("sw_adr_trunc", {8'd0, r_adr}, 32'h20);

    applyStimulus(1'b0, 32'h12, 32'h0, 3'd0);
    checkOutput("lb_lat", r_lat, 3);
    checkOutput("lb_data", r_rdata, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'h11, 32'h0, 3'd4);
    checkOutput("lbu_data", r_rdata, 32'h0000007F);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'd1);
    checkOutput("lh_data", r_rdata, 32'hFFFF80FF);

    applyStimulus(1'b1, 32'h23, 32'h000000AB, 3'd0);
    checkOutput("sb_sel", {28'd0, r_sel}, 32'h8);
    checkOutput("sb_dat", r_dat, 32'hABABABAB);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'd2);
    checkOutput("lw_after_sb", r_rdata, 32'hAB223344);
    applyStimulus(1'b0, 32'h22, 32'h0, 3'd5);
    checkOutput("lhu_data", r_rdata, 32'h0000AB22);

    applyStimulus(1'b1, 32'h16, 32'h1234BEEF, 3'd1);
    checkOutput("sh_sel", {28'd0, r_sel}, 32'hC);
    checkOutput("sh_dat", r_dat, 32'hBEEFBEEF);
    applyStimulus(1'b0, 32'h14, 32'h0, 3'd2);
    checkOutput("lw_after_sh", r_rdata, 32'hBEEF0045);

    applyStimulus(1'b0, 32'h06, 32'h0, 3'd2);
    checkOutput("mis_cyc", {31'd0, r_saw}, 32'h0);
    checkOutput("mis_lat", r_lat, 1);
    checkOutput("mis_err", {31'd0, r_err}, 32'h1);
    checkOutput("mis_code", {30'd0, r_code}, 32'h1);
    checkOutput("mis_rdata", r_rdata, 32'hBEEF0045);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd3);
    checkOutput("ill_cyc", {31'd0, r_saw}, 32'h0);
    checkOutput("ill_lat", r_lat, 1);
    checkOutput("ill_code", {30'd0, r_code}, 32'h1);
    checkOutput("code_after_done", {29'd0, done_o, err_code_o}, 32'h0);

    ack_en = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd2);
    ack_en = 1'b1;
    checkOutput("to_stb_cycles", r_stb, 4);
    checkOutput("to_lat", r_lat, 5);
    checkOutput("to_code", {30'd0, r_code}, 32'h2);
    checkOutput("to_err", {31'd0, r_err}, 32'h1);
    checkOutput("to_rdata", r_rdata, 32'hBEEF0045);

    ack_en = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; funct3_i = 3'd2;
    @(posedge CLK_I); #1;
    req_i = 1'b0;
    checkOutput("rst_in_bus", {31'd0, CYC_O}, 32'h1);
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    checkOutput("rst_cyc", {30'd0, CYC_O, busy_o}, 32'h0);
    checkOutput("rst_rdata", rdata_o, 32'h0);
    saw_done = 1'b0;
    repeat (4) begin
      if (done_o) saw_done = 1'b1;
      @(posedge CLK_I); #1;
    end
    checkOutput("rst_no_done", {31'd0, saw_done}, 32'h0);
    ack_en = 1'b1;
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd2);
    checkOutput("post_rst_lat", r_lat, 3);
    checkOutput("post_rst_data", r_rdata, 32'h80FF7F01);
    checkOutput("post_rst_err", {31'd0, r_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
